// File: rtl/rif_regbank_pkg.sv
// Register map, CTRL/IRQ bit positions and shared helpers
// for the RIF register bank with timer, irq and loopback FIFO.
package rif_regbank_pkg;

  localparam logic [4:0] OFS_ID          = 5'h00;
  localparam logic [4:0] OFS_SCRATCH     = 5'h04;
  localparam logic [4:0] OFS_CTRL        = 5'h08;
  localparam logic [4:0] OFS_TIMER_LOAD  = 5'h0C;
  localparam logic [4:0] OFS_TIMER_VALUE = 5'h10;
  localparam logic [4:0] OFS_IRQ_STATUS  = 5'h14;
  localparam logic [4:0] OFS_FIFO_DATA   = 5'h18;
  localparam logic [4:0] OFS_FIFO_STATUS = 5'h1C;

  localparam int CTRL_EN         = 0;
  localparam int CTRL_ONESHOT    = 1;
  localparam int CTRL_IRQ_EN_LSB = 4;

  localparam int IRQ_TMR_EXP  = 0;
  localparam int IRQ_EXT_EVT  = 1;
  localparam int IRQ_FIFO_OVF = 2;
  localparam int IRQ_FIFO_UDF = 3;
  localparam int IRQ_W        = 4;

  typedef struct packed {
    logic [IRQ_W-1:0] irq_en;
    logic             oneshot;
    logic             en;
  } ctrl_t;

  function automatic logic [31:0] merge_bytes(
    input logic [31:0] old,
    input logic [31:0] wdata,
    input logic [3:0]  wstrb
  );
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) r[8*b +: 8] = wdata[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/rif_sync_fifo.sv
// Synchronous word FIFO, power-of-2 depth, head visible without popping.
// Ports: clk, rst_n (sync), push/data, pop, full, empty, count, head.
module rif_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rptr;
  logic [PW-1:0]    wptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= data;
        wptr      <= wptr + PW'(1);
      end
      if (do_pop) rptr <= rptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/rif_regbank_timer.sv
// RIF slave: ID/scratch/ctrl bank, reloadable down-counter, W1C irq status
// and loopback FIFO. Ports: HCLK, HRESETn, rif_* bus, ext_event, irq.
module rif_regbank_timer
  import rif_regbank_pkg::*;
#(
  parameter int          ADDR_WIDTH = 12,
  parameter int          DATA_WIDTH = 32,
  parameter int          BYTE_COUNT = DATA_WIDTH / 8,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] BLOCK_ID   = 32'h5249_0001
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic [ADDR_WIDTH-1:0] rif_addr,
  output logic                  rif_addr_valid,
  input  logic                  rif_wr_req,
  input  logic                  rif_rd_req,
  input  logic [BYTE_COUNT-1:0] rif_wstrb,
  input  logic [DATA_WIDTH-1:0] rif_wdata,
  output logic [DATA_WIDTH-1:0] rif_rdata,
  input  logic                  ext_event,
  output logic                  irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  if (DATA_WIDTH != 32) begin : g_dw_chk
    $fatal(1, "rif_regbank_timer: DATA_WIDTH must be 32");
  end
  if (ADDR_WIDTH < 5) begin : g_aw_chk
    $fatal(1, "rif_regbank_timer: ADDR_WIDTH must be >= 5");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_fd_chk
    $fatal(1, "rif_regbank_timer: bad FIFO_DEPTH");
  end

  ctrl_t            ctrl;
  ctrl_t            ctrl_new;
  logic [31:0]      ctrl_rd;
  logic [31:0]      scratch;
  logic [31:0]      tload;
  logic [31:0]      tval;
  logic [31:0]      load_new;
  logic [IRQ_W-1:0] status;
  logic [IRQ_W-1:0] irq_set;
  logic [IRQ_W-1:0] irq_clr;
  logic [31:0]      fifo_st;
  logic [31:0]      rd_mux;
  logic [4:0]       ofs;
  logic             wr_en;
  logic             rd_en;
  logic             wr_ctrl;
  logic             wr_load;
  logic             wr_irq;
  logic             wr_fifo;
  logic             rd_fifo;
  logic             expire;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [31:0]      fifo_head;
  logic             unused_ok;

  assign unused_ok = &{1'b0, rif_addr[1:0]};

  assign rif_addr_valid = ((rif_addr >> 5) == '0);
  assign ofs     = {rif_addr[4:2], 2'b00};
  assign wr_en   = rif_wr_req & rif_addr_valid;
  assign rd_en   = rif_rd_req & rif_addr_valid;
  assign wr_ctrl = wr_en & (ofs == OFS_CTRL);
  assign wr_load = wr_en & (ofs == OFS_TIMER_LOAD);
  assign wr_irq  = wr_en & (ofs == OFS_IRQ_STATUS);
  assign wr_fifo = wr_en & (ofs == OFS_FIFO_DATA);
  assign rd_fifo = rd_en & (ofs == OFS_FIFO_DATA);

  assign ctrl_rd = {24'b0, ctrl.irq_en, 2'b00, ctrl.oneshot, ctrl.en};

  always_comb begin
    logic [31:0] m;
    m = merge_bytes(ctrl_rd, rif_wdata, rif_wstrb);
    ctrl_new.irq_en  = m[CTRL_IRQ_EN_LSB +: IRQ_W];
    ctrl_new.oneshot = m[CTRL_ONESHOT];
    ctrl_new.en      = m[CTRL_EN];
  end

  assign load_new = merge_bytes(tload, rif_wdata, rif_wstrb);

  // A LOAD write in the expiry cycle pre-empts the expiry.
  assign expire = ctrl.en & (tval == '0) & ~wr_load;

  always_comb begin
    irq_set               = '0;
    irq_set[IRQ_TMR_EXP]  = expire;
    irq_set[IRQ_EXT_EVT]  = ext_event;
    irq_set[IRQ_FIFO_OVF] = wr_fifo & fifo_full;
    irq_set[IRQ_FIFO_UDF] = rd_fifo & fifo_empty;
  end

  assign irq_clr = wr_irq ?
    (rif_wdata[IRQ_W-1:0] & {IRQ_W{rif_wstrb[0]}}) : '0;

  rif_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .push  (wr_fifo),
    .data  (rif_wdata),
    .pop   (rd_fifo),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (fifo_head)
  );

  always_comb begin
    fifo_st      = '0;
    fifo_st[4:0] = 5'(fifo_count);
    fifo_st[8]   = fifo_empty;
    fifo_st[9]   = fifo_full;
  end

  always_comb begin
    rd_mux = '0;
    unique case (ofs)
      OFS_ID:          rd_mux = BLOCK_ID;
      OFS_SCRATCH:     rd_mux = scratch;
      OFS_CTRL:        rd_mux = ctrl_rd;
      OFS_TIMER_LOAD:  rd_mux = tload;
      OFS_TIMER_VALUE: rd_mux = tval;
      OFS_IRQ_STATUS:  rd_mux = {{(32-IRQ_W){1'b0}}, status};
      OFS_FIFO_DATA:   rd_mux = fifo_head;
      OFS_FIFO_STATUS: rd_mux = fifo_st;
      default:         rd_mux = '0;
    endcase
  end

  assign rif_rdata = rif_addr_valid ? rd_mux : '0;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      ctrl    <= '0;
      scratch <= '0;
      tload   <= '0;
      tval    <= '0;
      status  <= '0;
      irq     <= 1'b0;
    end else begin
      if (wr_en && ofs == OFS_SCRATCH) begin
        scratch <= merge_bytes(scratch, rif_wdata, rif_wstrb);
      end
      if (wr_ctrl) begin
        ctrl <= ctrl_new;
      end else if (expire && ctrl.oneshot) begin
        ctrl.en <= 1'b0;
      end
      if (wr_load) begin
        tload <= load_new;
        tval  <= load_new;
      end else if (ctrl.en) begin
        if (tval != '0) tval <= tval - 32'd1;
        else if (!ctrl.oneshot) tval <= tload;
      end
      // Set wins over a same-cycle W1C clear.
      status <= (status & ~irq_clr) | irq_set;
      irq    <= |(status & ctrl.irq_en);
    end
  end

endmodule

// File: tb/tb_rif_regbank_timer.sv
// Directed bench for rif_regbank_timer with a cycle model and
// a negedge compare process plus literal spot checks.
module tb_rif_regbank_timer;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [11:0] rif_addr;
  logic        rif_addr_valid;
  logic        rif_wr_req;
  logic        rif_rd_req;
  logic [3:0]  rif_wstrb;
  logic [31:0] rif_wdata;
  logic [31:0] rif_rdata;
  logic        ext_event;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 0;

  // Model state
  logic [31:0] m_scratch, m_ctrl, m_load, m_val;
  logic [3:0]  m_st;
  logic        m_irq;
  logic [31:0] m_q[$];

  always #5 HCLK = ~HCLK;

  rif_regbank_timer dut (
    .HCLK           (HCLK),
    .HRESETn        (HRESETn),
    .rif_addr       (rif_addr),
    .rif_addr_valid (rif_addr_valid),
    .rif_wr_req     (rif_wr_req),
    .rif_rd_req     (rif_rd_req),
    .rif_wstrb      (rif_wstrb),
    .rif_wdata      (rif_wdata),
    .rif_rdata      (rif_rdata),
    .ext_event      (ext_event),
    .irq            (irq)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(logic [11:0] a);
    int n;
    n = m_q.size();
    if ((a >> 5) != 0) return 32'h0;
    case (a[4:2])
      3'd0: return 32'h5249_0001;
      3'd1: return m_scratch;
      3'd2: return m_ctrl;
      3'd3: return m_load;
      3'd4: return m_val;
      3'd5: return {28'h0, m_st};
      3'd6: return (n == 0) ? 32'h0 : m_q[0];
      default: return ((n == 4) ? 32'h200 : 32'h0) |
                      ((n == 0) ? 32'h100 : 32'h0) | 32'(n);
    endcase
  endfunction

  function automatic logic [31:0] lanes(logic [3:0] s);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{s[b]}};
    return m;
  endfunction

  task automatic model_step();
    bit          v, wr, rd, exp_t;
    logic [2:0]  idx;
    logic [31:0] mk, n_ctrl, n_val;
    logic [3:0]  set, clr;
    logic        n_irq;
    if (!HRESETn) begin
      m_scratch = 0; m_ctrl = 0; m_load = 0; m_val = 0;
      m_st = 0; m_irq = 0; m_q.delete();
      return;
    end
    v   = ((rif_addr >> 5) == 0);
    idx = rif_addr[4:2];
    wr  = rif_wr_req && v;
    rd  = rif_rd_req && v;
    mk  = lanes(rif_wstrb);
    n_irq  = |(m_st & m_ctrl[7:4]);
    set = 0; clr = 0;
    n_ctrl = m_ctrl;
    n_val  = m_val;
    exp_t  = m_ctrl[0] && m_val == 0 && !(wr && idx == 3);
    if (m_ctrl[0]) begin
      if (m_val != 0) n_val = m_val - 1;
      else if (!m_ctrl[1]) n_val = m_load;
    end
    if (exp_t) begin
      set[0] = 1;
      if (m_ctrl[1]) n_ctrl[0] = 0;
    end
    if (ext_event) set[1] = 1;
    if (wr) begin
      case (idx)
        3'd1: m_scratch = (m_scratch & ~mk) | (rif_wdata & mk);
        3'd2: n_ctrl = ((m_ctrl & ~mk) | (rif_wdata & mk)) & 32'hF3;
        3'd3: begin
          m_load = (m_load & ~mk) | (rif_wdata & mk);
          n_val  = m_load;
        end
        3'd5: clr = rif_wdata[3:0] & {4{rif_wstrb[0]}};
        3'd6: if (m_q.size() == 4) set[2] = 1;
              else m_q.push_back(rif_wdata);
        default: ;
      endcase
    end
    if (rd && idx == 6) begin
      if (m_q.size() == 0) set[3] = 1;
      else void'(m_q.pop_front());
    end
    m_st   = (m_st & ~clr) | set;
    m_ctrl = n_ctrl;
    m_val  = n_val;
    m_irq  = n_irq;
  endtask

  always @(negedge HCLK) begin
    if (cmp_en) begin
      chk("rdata", rif_rdata, m_read(rif_addr));
      chk("addr_valid", {31'b0, rif_addr_valid},
          {31'b0, (rif_addr >> 5) == 0});
      chk("irq", {31'b0, irq}, {31'b0, m_irq});
    end
  end

  task automatic tick();
    @(posedge HCLK);
    model_step();
    #1;
  endtask

  task automatic drive(bit wr, bit rd, logic [11:0] a, logic [3:0] s,
                       logic [31:0] d, bit ev);
    rif_wr_req = wr; rif_rd_req = rd; rif_addr = a;
    rif_wstrb = s; rif_wdata = d; ext_event = ev;
    tick();
    rif_wr_req = 0; rif_rd_req = 0; ext_event = 0;
  endtask

  task automatic wr(logic [11:0] a, logic [3:0] s, logic [31:0] d);
    drive(1, 0, a, s, d, 0);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic peek(logic [11:0] a, logic [31:0] e, string nm);
    rif_wr_req = 0; rif_rd_req = 0; rif_addr = a;
    #1;
    chk(nm, rif_rdata, e);
  endtask

  initial begin
    HRESETn = 0; rif_addr = 0; rif_wr_req = 0; rif_rd_req = 0;
    rif_wstrb = 0; rif_wdata = 0; ext_event = 0;
    tick();
    cmp_en = 1;
    tick();
    HRESETn = 1;
    chk("irq_reset", {31'b0, irq}, 32'h0);
    peek(12'h000, 32'h5249_0001, "id");
    peek(12'h004, 32'h0, "scratch_reset");
    peek(12'h01C, 32'h100, "fifo_st_reset");

    wr(12'h004, 4'b0101, 32'hAABB_CCDD);
    peek(12'h004, 32'h00BB_00DD, "scratch_wstrb");
    wr(12'h044, 4'hF, 32'h1234_5678);
    peek(12'h004, 32'h00BB_00DD, "scratch_alias");
    peek(12'h040, 32'h0, "rdata_invalid");
    chk("valid_invalid", {31'b0, rif_addr_valid}, 32'h0);
    wr(12'h000, 4'hF, 32'hFFFF_FFFF);
    peek(12'h000, 32'h5249_0001, "id_ro");

    // Periodic timer
    wr(12'h00C, 4'hF, 32'd3);
    wr(12'h008, 4'hF, 32'h11);
    peek(12'h010, 32'd3, "tval_3");
    idle(3);
    peek(12'h010, 32'd0, "tval_0");
    idle(1);
    peek(12'h010, 32'd3, "tval_reload");
    peek(12'h014, 32'h1, "st_exp");
    chk("irq_lat0", {31'b0, irq}, 32'h0);
    idle(1);
    chk("irq_lat1", {31'b0, irq}, 32'h1);
    wr(12'h014, 4'hF, 32'h1);
    peek(12'h014, 32'h0, "st_w1c");
    chk("irq_hold", {31'b0, irq}, 32'h1);
    idle(1);
    chk("irq_drop", {31'b0, irq}, 32'h0);
    wr(12'h008, 4'hF, 32'h0);
    wr(12'h014, 4'hF, 32'hF);

    // Oneshot timer
    wr(12'h00C, 4'hF, 32'd2);
    wr(12'h008, 4'hF, 32'h13);
    idle(3);
    peek(12'h008, 32'h12, "oneshot_ctrl");
    peek(12'h010, 32'h0, "oneshot_val");
    peek(12'h014, 32'h1, "oneshot_st");
    idle(3);
    peek(12'h010, 32'h0, "oneshot_hold");
    wr(12'h014, 4'hF, 32'hF);

    // FIFO fill, overflow, drain, underflow
    for (int i = 1; i <= 5; i++) begin
      wr(12'h018, 4'hF, 32'(i));
      if (i == 4) peek(12'h01C, 32'h204, "fifo_full");
    end
    peek(12'h014, 32'h4, "fifo_ovf");
    peek(12'h01C, 32'h204, "fifo_full_after_ovf");
    for (int i = 1; i <= 5; i++) begin
      rif_addr = 12'h018; rif_rd_req = 1;
      #1;
      chk("fifo_pop", rif_rdata, (i < 5) ? 32'(i) : 32'h0);
      tick();
      rif_rd_req = 0;
      if (i <= 4)
        peek(12'h01C, 32'(4 - i) | ((i == 4) ? 32'h100 : 32'h0),
             "fifo_count");
    end
    peek(12'h01C, 32'h100, "fifo_empty");
    peek(12'h014, 32'hC, "fifo_udf");

    // ext_event set versus W1C clear
    wr(12'h014, 4'hF, 32'hF);
    drive(0, 0, 12'h014, 4'h0, 32'h0, 1);
    peek(12'h014, 32'h2, "ext_set");
    drive(1, 0, 12'h014, 4'hF, 32'h2, 1);
    peek(12'h014, 32'h2, "ext_set_wins");
    wr(12'h014, 4'hF, 32'h2);
    peek(12'h014, 32'h0, "ext_clr");

    // Reset mid-operation
    wr(12'h00C, 4'hF, 32'd10);
    wr(12'h008, 4'hF, 32'h01);
    wr(12'h018, 4'hF, 32'h77);
    idle(2);
    HRESETn = 0;
    tick();
    HRESETn = 1;
    peek(12'h01C, 32'h100, "rst_fifo");
    peek(12'h010, 32'h0, "rst_tval");
    peek(12'h008, 32'h0, "rst_ctrl");
    peek(12'h018, 32'h0, "rst_head");
    idle(2);

    cmp_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
